// File: rtl/d_load_responder.sv
// Data-load responder: checks a physical load, reads one word from the data SRAM after
// programmable wait states and returns right-aligned, size-masked data with an ack pulse.
package riscv_pkg;
    typedef logic [63:0] addr_t;
endpackage

package tortoise_pkg;
    typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_8B} size_e;

    typedef struct packed {
        riscv_pkg::addr_t addr;
        size_e            size;
    } phy_load_t;
endpackage

module d_load_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic                    d_load_req_i,
    input  tortoise_pkg::phy_load_t d_load_i,
    output logic                    d_load_ack_o,
    output logic                    d_load_err_o,
    output logic [63:0]             d_load_data_o,
    output logic                    mem_req_o,
    output logic [IDX_W-1:0]        mem_idx_o,
    input  logic [63:0]             mem_rdata_i
);
    import tortoise_pkg::*;

    // Computed in 65 bits so a window touching the top of the address space cannot wrap.
    localparam logic [64:0] WinEnd = {1'b0, BASE_ADDR} + (65'(DEPTH_WORDS) << 3);

    typedef enum logic [2:0] {StIdle, StWait, StRead, StResp, StErr} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    riscv_pkg::addr_t addr_q, addr_d;
    size_e            size_q, size_d;

    logic        misaligned, out_of_range, fault;
    logic [63:0] shifted, size_mask;

    always_comb begin
        misaligned = 1'b0;
        unique case (d_load_i.size)
            SZ_1B:   misaligned = 1'b0;
            SZ_2B:   misaligned = d_load_i.addr[0];
            SZ_4B:   misaligned = |d_load_i.addr[1:0];
            SZ_8B:   misaligned = |d_load_i.addr[2:0];
            default: misaligned = 1'b1;
        endcase
        out_of_range = (d_load_i.addr < BASE_ADDR) || ({1'b0, d_load_i.addr} >= WinEnd);
        fault        = misaligned || out_of_range;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_1B;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (d_load_req_i) begin
                        addr_d = d_load_i.addr;
                        size_d = d_load_i.size;
                        if (fault) begin
                            state_d = StErr;
                        end else if (WAIT_CYCLES > 0) begin
                            state_d = StWait;
                            cnt_d   = 4'(WAIT_CYCLES - 1);
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
                StWait: begin
                    if (!d_load_req_i) begin
                        state_d = StIdle;
                    end else if (cnt_q == 4'd0) begin
                        state_d = StRead;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StRead:  state_d = d_load_req_i ? StResp : StIdle;
                StResp:  state_d = StIdle;
                StErr:   state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    assign shifted = mem_rdata_i >> {addr_q[2:0], 3'b000};

    always_comb begin
        size_mask = '1;
        unique case (size_q)
            SZ_1B:   size_mask = 64'h0000_0000_0000_00FF;
            SZ_2B:   size_mask = 64'h0000_0000_0000_FFFF;
            SZ_4B:   size_mask = 64'h0000_0000_FFFF_FFFF;
            SZ_8B:   size_mask = '1;
            default: size_mask = '1;
        endcase
    end

    // A withdrawn request or a flush kills every handshake output in the same cycle.
    always_comb begin
        d_load_ack_o  = 1'b0;
        d_load_err_o  = 1'b0;
        d_load_data_o = '0;
        mem_req_o     = 1'b0;
        mem_idx_o     = '0;
        unique case (state_q)
            StRead: begin
                mem_req_o = d_load_req_i && !flush_i;
                mem_idx_o = IDX_W'((addr_q - BASE_ADDR) >> 3);
            end
            StResp: begin
                d_load_ack_o  = d_load_req_i && !flush_i;
                d_load_data_o = shifted & size_mask;
            end
            StErr: begin
                d_load_ack_o = d_load_req_i && !flush_i;
                d_load_err_o = d_load_req_i && !flush_i;
            end
            default: ;
        endcase
    end

endmodule
